uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter: 8 data bits, no parity, 1 stop bit (8N1), LSB first, idle-high line. It is the transmit counterpart to `UART_RX` on the same link and uses the same cycles-per-bit parameterisation, so the two can be looped back directly. A one-byte holding register, filled through a valid/ready handshake, lets a second byte queue during a frame so consecutive frames go out with no idle gap.

## Interface
- `c_CYCLES_PER_BIT`, default 434 (50 MHz / 115200). Clock cycles per serial bit; must be ≥ 2.
- `i_CLK`  in  1  system clock; all logic on its rising edge.
- `i_RESET_N`  in  1  asynchronous, active-low reset.
- `i_DATA_TX`  in  8  byte to send; sampled when `i_TX_DATA_VALID && o_TX_READY`.
- `i_TX_DATA_VALID`  in  1  byte-offer strobe.
- `o_TX_READY`  out  1  high when the holding register is empty.
- `o_SERIAL_DATA`  out  1  registered serial line.
- `o_TX_ACTIVE`  out  1  high while a frame is on the line (START/DATA/STOP).
- `o_TX_DONE`  out  1  one-cycle pulse at the end of each frame.

## Operation
- Storage:
  - holding register + `full` flag; `o_TX_READY = !full`.
  - 8-bit shift register.
  - baud counter, width `$clog2(c_CYCLES_PER_BIT)`, counting 0..`c_CYCLES_PER_BIT`-1.
  - 3-bit bit index.
- State machine: IDLE, START, DATA, STOP.
- IDLE:
  - Line high.
  - If `full`: move the holding register into the shifter, clear `full`, go to START.
  - Else if valid: load `i_DATA_TX` straight into the shifter (bypass), go to START. `full` stays 0.
- START: line 0 for `c_CYCLES_PER_BIT` cycles, then go to DATA with bit index 0.
- DATA:
  - Line = shifter[0] for `c_CYCLES_PER_BIT` cycles, then shift right and increment the index.
  - After index 7 completes, go to STOP.
- STOP:
  - Line 1 for `c_CYCLES_PER_BIT` cycles.
  - `o_TX_DONE` is high in the last cycle of the stop bit.
  - At the end of the stop bit: if `full`, load the shifter from the holding register, clear `full`, go to START in the next cycle (zero idle cycles). Otherwise go to IDLE.
- Handshake when not in IDLE:
  - valid && ready sets `full` and captures `i_DATA_TX`.
  - While `full`, valid is ignored. The source must hold its byte until it sees ready.
- Simultaneous events: in the stop-end cycle with `full`=1, ready is 0, so no capture occurs. Ready returns to 1 in the following cycle.
- Reset (asserted at any time, including mid-frame):
  - `o_SERIAL_DATA`=1, `o_TX_READY`=1, `o_TX_ACTIVE`=0, `o_TX_DONE`=0.
  - State IDLE; counters 0; `full`=0.
  - Any in-flight or queued byte is discarded; no partial frame resumes.

## Timing
- Accept-to-line latency from IDLE: byte captured at edge k; `o_SERIAL_DATA` falls after edge k, so the start bit occupies cycles k+1 … k+`c_CYCLES_PER_BIT`.
- Frame length: exactly 10×`c_CYCLES_PER_BIT` cycles. Every bit period is exact, with no ±1 drift.
- `o_TX_ACTIVE` rises with the start bit and falls after the last stop cycle. It stays high across back-to-back frames.
- `o_TX_DONE`: exactly one cycle per frame, coincident with the last stop-bit cycle.
- Back-to-back throughput: one byte per 10×`c_CYCLES_PER_BIT` cycles, continuous.

## Test plan
Bench uses `c_CYCLES_PER_BIT`=16.
- Single byte 0x26 from IDLE:
  - Line reads, per 16-cycle bit: 0 | 0,1,1,0,0,1,0,0 | 1.
  - `o_TX_DONE` pulses once at cycle 160 after accept.
  - Looped into `UART_RX` with the same parameter, `o_DATA_RX`=0x26 with valid.
- Back-to-back 0xA5 then 0x3C, second offered while the first is in DATA:
  - Second is accepted immediately and ready drops.
  - 320 contiguous line cycles with no high gap between the stop bit and the next start bit.
  - Two DONE pulses 160 cycles apart.
- Third byte 0x5A offered while `full`=1, valid held:
  - Not captured until ready rises, in the cycle after the first frame's stop end.
  - Transmitted third; byte order is preserved.
- Boundary data 0x00 and 0xFF:
  - 0x00: line low for 144 consecutive cycles, then 16 high.
  - 0xFF: line low 16 cycles, then 144 high.
- Reset asserted at cycle 70 of a frame, with a byte queued:
  - Line goes high immediately; ready=1, active=0.
  - No DONE pulse; queued byte never appears.
  - After release, a new byte 0x81 transmits correctly.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, idle-high line, with a one-byte holding
// register so a queued byte follows the current frame with no idle gap.
module uart_tx #(
   parameter int c_CYCLES_PER_BIT = 434
) (
   input  logic       i_CLK,
   input  logic       i_RESET_N,
   input  logic [7:0] i_DATA_TX,
   input  logic       i_TX_DATA_VALID,
   output logic       o_TX_READY,
   output logic       o_SERIAL_DATA,
   output logic       o_TX_ACTIVE,
   output logic       o_TX_DONE
);

   localparam int CNT_W = $clog2(c_CYCLES_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(c_CYCLES_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] baud_cnt, baud_cnt_nxt;
   logic [2:0]       bit_idx, bit_idx_nxt;
   logic [7:0]       shifter, shifter_nxt;
   logic [7:0]       hold, hold_nxt;
   logic             full, full_nxt;
   logic             serial_nxt;
   logic             bit_end;

   assign bit_end     = (baud_cnt == CNT_MAX);
   assign o_TX_READY  = !full;
   assign o_TX_ACTIVE = (state != IDLE);
   assign o_TX_DONE   = (state == STOP) && bit_end;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_nxt    = state;
      baud_cnt_nxt = baud_cnt;
      bit_idx_nxt  = bit_idx;
      shifter_nxt  = shifter;
      hold_nxt     = hold;
      full_nxt     = full;

      unique case (state)
         IDLE: begin
            baud_cnt_nxt = '0;
            bit_idx_nxt  = '0;
            if (full) begin
               shifter_nxt = hold;
               full_nxt    = 1'b0;
               state_nxt   = START;
            end else if (i_TX_DATA_VALID) begin
               shifter_nxt = i_DATA_TX;
               state_nxt   = START;
            end
         end
         START: begin
            if (bit_end) begin
               baud_cnt_nxt = '0;
               bit_idx_nxt  = '0;
               state_nxt    = DATA;
            end else begin
               baud_cnt_nxt = baud_cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_cnt_nxt = '0;
               shifter_nxt  = {1'b0, shifter[7:1]};
               bit_idx_nxt  = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_nxt = STOP;
            end else begin
               baud_cnt_nxt = baud_cnt + CNT_W'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_cnt_nxt = '0;
               if (full) begin
                  shifter_nxt = hold;
                  full_nxt    = 1'b0;
                  state_nxt   = START;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               baud_cnt_nxt = baud_cnt + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Queue a byte only mid-frame; in IDLE the offered byte bypasses the holding register.
      if (state != IDLE && i_TX_DATA_VALID && !full) begin
         hold_nxt = i_DATA_TX;
         full_nxt = 1'b1;
      end

      // Line is registered from the next state so it changes on the accepting edge.
      unique case (state_nxt)
         START:   serial_nxt = 1'b0;
         DATA:    serial_nxt = shifter_nxt[0];
         default: serial_nxt = 1'b1;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge i_CLK or negedge i_RESET_N) begin
      if (!i_RESET_N) begin
         state         <= IDLE;
         baud_cnt      <= '0;
         bit_idx       <= '0;
         shifter       <= '0;
         hold          <= '0;
         full          <= 1'b0;
         o_SERIAL_DATA <= 1'b1;
      end else begin
         state         <= state_nxt;
         baud_cnt      <= baud_cnt_nxt;
         bit_idx       <= bit_idx_nxt;
         shifter       <= shifter_nxt;
         hold          <= hold_nxt;
         full          <= full_nxt;
         o_SERIAL_DATA <= serial_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 16 cycles per bit: single frames, back-to-back
// queueing, held offers while full, boundary bytes and mid-frame reset.
module tb_uart_tx;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data = 8'h00;
   logic       valid = 1'b0;
   logic       rdy, ser, act, done;

   int total = 0;
   int bad = 0;

   logic line_q[0:699];
   logic done_q[0:699];
   logic act_q[0:699];
   logic rdy_q[0:699];
   int   acc_idx[3];

   always #5 clk = ~clk;

   uart_tx #(.c_CYCLES_PER_BIT(CPB)) dut (
      .i_CLK           (clk),
      .i_RESET_N       (rst_n),
      .i_DATA_TX       (data),
      .i_TX_DATA_VALID (valid),
      .o_TX_READY      (rdy),
      .o_SERIAL_DATA   (ser),
      .o_TX_ACTIVE     (act),
      .o_TX_DONE       (done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Records n cycles of outputs; offers byte q at cycle ot[q] and holds it until accepted.
   task automatic capture(input int n, input int no,
                          input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input int t0, input int t1, input int t2);
      logic [7:0] ob[3];
      int         ot[3];
      int         qi;
      logic       fire;
      ob = '{b0, b1, b2};
      ot = '{t0, t1, t2};
      qi = 0;
      for (int k = 0; k < 3; k++) acc_idx[k] = -1;
      for (int i = 0; i < n; i++) begin
         line_q[i] = ser;
         done_q[i] = done;
         act_q[i]  = act;
         rdy_q[i]  = rdy;
         if (!valid && qi < no && i >= ot[qi]) begin
            data  = ob[qi];
            valid = 1'b1;
         end
         fire = valid && rdy;
         step();
         if (fire) begin
            acc_idx[qi] = i;
            qi++;
            valid = 1'b0;
         end
      end
      valid = 1'b0;
   endtask

   // sel: 0 line, 1 done, 2 active; counts cycles in [lo,hi] equal to val.
   function automatic int count(input int sel, input logic val, input int lo, input int hi);
      int c = 0;
      for (int i = lo; i <= hi; i++) begin
         logic v;
         v = (sel == 0) ? line_q[i] : (sel == 1) ? done_q[i] : act_q[i];
         if (v === val) c++;
      end
      return c;
   endfunction

   task automatic check_frame(input string tag, input int base, input logic [7:0] b);
      logic [9:0]  fr;
      logic [15:0] w;
      logic [7:0]  dec;
      fr = {1'b1, b, 1'b0};
      for (int bt = 0; bt < 10; bt++) begin
         for (int j = 0; j < CPB; j++) w[j] = line_q[base + bt*CPB + j];
         check($sformatf("%s_bit%0d", tag, bt), {16'h0, w}, fr[bt] ? 32'hFFFF : 32'h0);
      end
      for (int d = 0; d < 8; d++) dec[d] = line_q[base + (d+1)*CPB + CPB/2];
      check($sformatf("%s_rx", tag), {24'h0, dec}, {24'h0, b});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_ser", ser, 1);
      check("rst_rdy", rdy, 1);
      check("rst_act", act, 0);
      check("rst_done", done, 0);
      rst_n = 1'b1;
      step();

      // Single byte 0x26 from IDLE
      capture(170, 1, 8'h26, 8'h00, 8'h00, 0, 0, 0);
      check("t1_acc", acc_idx[0], 0);
      check_frame("t1_26", 1, 8'h26);
      check("t1_done_cnt", count(1, 1'b1, 0, 169), 1);
      check("t1_done_at160", done_q[160], 1);
      check("t1_act_last", act_q[160], 1);
      check("t1_act_after", act_q[161], 0);
      check("t1_idle_line", line_q[161], 1);

      // 0xA5 then 0x3C queued during DATA, 0x5A held while full
      capture(490, 3, 8'hA5, 8'h3C, 8'h5A, 0, 40, 60);
      check("t2_acc0", acc_idx[0], 0);
      check("t2_acc1", acc_idx[1], 40);
      check("t2_rdy_drop", rdy_q[41], 0);
      check("t2_rdy_stopend", rdy_q[160], 0);
      check("t2_rdy_rise", rdy_q[161], 1);
      check("t2_acc2", acc_idx[2], 161);
      check_frame("t2_a5", 1, 8'hA5);
      check_frame("t2_3c", 161, 8'h3C);
      check_frame("t2_5a", 321, 8'h5A);
      check("t2_done_cnt", count(1, 1'b1, 0, 489), 3);
      check("t2_done1", done_q[160], 1);
      check("t2_done2", done_q[320], 1);
      check("t2_done3", done_q[480], 1);
      check("t2_act_gap", count(2, 1'b0, 1, 480), 0);
      check("t2_act_end", act_q[481], 0);

      // Boundary bytes 0x00 and 0xFF back to back
      capture(330, 2, 8'h00, 8'hFF, 8'h00, 0, 5, 0);
      check("t3_acc1", acc_idx[1], 5);
      check("t3_low_run", count(0, 1'b0, 1, 144), 144);
      check_frame("t3_00", 1, 8'h00);
      check_frame("t3_ff", 161, 8'hFF);
      check("t3_ff_high", count(0, 1'b1, 177, 320), 144);

      // Reset mid-frame with 0x42 queued
      capture(71, 2, 8'h99, 8'h42, 8'h00, 0, 10, 0);
      check("t4_acc1", acc_idx[1], 10);
      rst_n = 1'b0;
      #1;
      check("t4_rst_ser", ser, 1);
      check("t4_rst_rdy", rdy, 1);
      check("t4_rst_act", act, 0);
      check("t4_rst_done", done, 0);
      step();
      step();
      rst_n = 1'b1;
      capture(200, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
      check("t4_no_done", count(1, 1'b1, 0, 199), 0);
      check("t4_no_low", count(0, 1'b0, 0, 199), 0);
      check("t4_no_act", count(2, 1'b1, 0, 199), 0);
      capture(170, 1, 8'h81, 8'h00, 8'h00, 0, 0, 0);
      check("t4_acc", acc_idx[0], 0);
      check_frame("t4_81", 1, 8'h81);
      check("t4_done_at160", done_q[160], 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
